rsa_cipher_feeder: RTL

Upstream stage of the RSA decrypt path. Accepts ciphertext bytes over a valid/ready handshake, screens out bytes that are not valid residues of the modulus, and buffers the rest in a small FIFO. It presents each buffered byte to the decrypt stage's `cipher` input, holding it stable for a fixed window sized to the decrypt stage's exponentiation latency. It pulses `dec_sample` on the window's last cycle so the downstream capture logic knows when `decrypted` is valid.

---
 rtl/rsa_cipher_feeder.sv | 123 ++++++++++++
 1 files changed

// File: rtl/rsa_cipher_feeder.sv
// Ciphertext feeder for the RSA decrypt stage: range-screens incoming bytes, buffers them
// in a small FIFO and holds each one on cipher for a fixed exponentiation window.
module rsa_cipher_feeder #(
  parameter int DEPTH       = 4,
  parameter int HOLD_CYCLES = 16,
  parameter int MODULUS     = 143
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       flush,
  input  logic                       in_valid,
  input  logic [7:0]                 in_data,
  output logic                       in_ready,
  output logic [7:0]                 cipher,
  output logic                       cipher_valid,
  output logic                       dec_sample,
  output logic [7:0]                 drop_cnt,
  output logic [$clog2(DEPTH+1)-1:0] fifo_count
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH+1);
  localparam int HW = $clog2(HOLD_CYCLES);
  localparam logic [8:0] MOD9 = 9'(MODULUS);

  typedef enum logic {IDLE, HOLD} state_t;

  state_t        r_state, w_state_nxt;
  logic [7:0]    r_mem [DEPTH];
  logic [AW-1:0] r_wptr, r_rptr;
  logic [CW-1:0] r_count;
  logic [HW-1:0] r_hold_cnt, w_hold_nxt;
  logic [7:0]    r_cipher, r_drop;
  logic          w_accept, w_in_range, w_push, w_pop, w_hold_done, w_nonempty;

  assign in_ready     = (r_count != CW'(DEPTH));
  assign w_accept     = in_valid && in_ready && !flush;
  assign w_in_range   = ({1'b0, in_data} < MOD9);
  assign w_push       = w_accept && w_in_range;
  assign w_nonempty   = (r_count != '0);
  assign w_hold_done  = (r_state == HOLD) && (r_hold_cnt == '0);

  assign cipher       = r_cipher;
  assign cipher_valid = (r_state == HOLD);
  assign dec_sample   = w_hold_done;
  assign drop_cnt     = r_drop;
  assign fifo_count   = r_count;

  // Pop decisions look at the registered count only, so a byte pushed this edge is never bypassed.
  always_comb begin
    w_state_nxt = r_state;
    w_hold_nxt  = r_hold_cnt;
    w_pop       = 1'b0;
    unique case (r_state)
      IDLE: begin
        if (w_nonempty) begin
          w_pop       = 1'b1;
          w_state_nxt = HOLD;
          w_hold_nxt  = HW'(HOLD_CYCLES - 1);
        end
      end
      HOLD: begin
        if (w_hold_done) begin
          if (w_nonempty) begin
            w_pop      = 1'b1;
            w_hold_nxt = HW'(HOLD_CYCLES - 1);
          end else begin
            w_state_nxt = IDLE;
          end
        end else begin
          w_hold_nxt = r_hold_cnt - 1'b1;
        end
      end
      default: w_state_nxt = IDLE;
    endcase
    if (flush) begin
      w_state_nxt = IDLE;
      w_hold_nxt  = '0;
      w_pop       = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state    <= IDLE;
      r_hold_cnt <= '0;
    end else begin
      r_state    <= w_state_nxt;
      r_hold_cnt <= w_hold_nxt;
    end
  end

  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wptr] <= in_data;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_wptr   <= '0;
      r_rptr   <= '0;
      r_count  <= '0;
      r_cipher <= '0;
      r_drop   <= '0;
    end else if (flush) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
    end else begin
      if (w_push) r_wptr <= r_wptr + 1'b1;
      if (w_pop) begin
        r_rptr   <= r_rptr + 1'b1;
        r_cipher <= r_mem[r_rptr];
      end
      unique case ({w_push, w_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
      if (w_accept && !w_in_range && (r_drop != 8'hFF)) r_drop <= r_drop + 1'b1;
    end
  end

endmodule
